// File: rtl/rv_dmem_ctrl_if.sv
// Request/response bus between the load/store unit (master) and rv_dmem_ctrl (slave).
interface rv_dmem_ctrl_if #(
  parameter int ADDR_WID = 32,
  parameter int DATA_WID = 64
);
  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic [2:0]          req_funct3;
  logic [ADDR_WID-1:0] req_addr;
  logic [DATA_WID-1:0] req_wdata;
  logic                rsp_valid;
  logic [DATA_WID-1:0] rsp_data;
  logic                rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/rv_dmem_ctrl.sv
// RV data memory controller: funct3-sized loads/stores into an internal single-port
// synchronous RAM, fixed-latency response pipeline (RD_LAT cycles) and error reporting.
// Optional misaligned-access checking is enabled by defining RV_DMEM_MISALIGN_CHK_EN;
// without it, misaligned accesses are silently aligned down to the access size.
module rv_dmem_ctrl #(
  parameter int ADDR_WID   = 32,
  parameter int DATA_WID   = 64,
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_LAT     = 1
) (
  input  logic           clk,
  input  logic           rst,
  rv_dmem_ctrl_if.slave  bus
);

  localparam int NB    = DATA_WID / 8;
  localparam int OFF   = $clog2(NB);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DATA_WID-1:0] ONE_W = {{(DATA_WID-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic           valid;
    logic           we;
    logic [2:0]     funct3;
    logic [OFF-1:0] off;
    logic           err;
  } meta_t;

  logic [DATA_WID-1:0]   mem [DEPTH];
  logic [DATA_WID-1:0]   data_q [RD_LAT];
  meta_t                 meta_q [RD_LAT];
  meta_t                 meta_d;

  logic                  accept;
  logic [DEPTH_LOG2-1:0] wordIdx;
  logic [OFF-1:0]        rawOff;
  logic [OFF-1:0]        effOff;
  logic [3:0]            sizeMaskFull;
  logic [OFF-1:0]        sizeMask;
  logic                  widthErr;
  logic                  misErr;
  logic                  reqErr;
  logic                  doWrite;
  logic                  doRead;
  logic [NB-1:0]         byteEn;
  logic [DATA_WID-1:0]   wrData;
  logic                  unusedAddrBits;

  assign bus.req_ready = !rst;
  assign accept        = bus.req_valid && !rst;
  assign wordIdx       = bus.req_addr[DEPTH_LOG2+OFF-1:OFF];
  assign rawOff        = bus.req_addr[OFF-1:0];
  assign unusedAddrBits = ^bus.req_addr[ADDR_WID-1:DEPTH_LOG2+OFF];

  // Decode access size into an offset mask, then classify width and alignment errors
  always_comb begin
    sizeMaskFull = (4'd1 << bus.req_funct3[1:0]) - 4'd1;
    sizeMask     = sizeMaskFull[OFF-1:0];
    widthErr     = (DATA_WID == 32) &&
                   ((bus.req_funct3[1:0] == 2'b11) || (!bus.req_we && bus.req_funct3 == 3'b110));
`ifdef RV_DMEM_MISALIGN_CHK_EN
    effOff = rawOff;
    misErr = |(rawOff & sizeMask);
`else
    effOff = rawOff & ~sizeMask;
    misErr = 1'b0;
`endif
    reqErr  = widthErr || misErr;
    doWrite = accept && bus.req_we && !reqErr;
    doRead  = accept && !bus.req_we && !reqErr;
  end

  // Build byte-lane enables for the addressed bytes and replicate store data across lanes
  always_comb begin
    int bytesN;
    bytesN = 1 << bus.req_funct3[1:0];
    byteEn = '0;
    wrData = '0;
    for (int b = 0; b < NB; b++) begin
      if ((b >= int'(effOff)) && (b < int'(effOff) + bytesN)) begin
        byteEn[b] = 1'b1;
      end
      wrData[8*b +: 8] = bus.req_wdata[8*(b % bytesN) +: 8];
    end
  end

  // Single-port RAM: byte-masked write and registered read at the accept edge, then data delay stages
  always_ff @(posedge clk) begin
    if (doWrite) begin
      for (int b = 0; b < NB; b++) begin
        if (byteEn[b]) begin
          mem[wordIdx][8*b +: 8] <= wrData[8*b +: 8];
        end
      end
    end
    if (doRead) begin
      data_q[0] <= mem[wordIdx];
    end
    for (int s = 1; s < RD_LAT; s++) begin
      data_q[s] <= data_q[s-1];
    end
  end

  // Capture the per-request attributes entering the response pipeline
  always_comb begin
    meta_d        = '0;
    meta_d.valid  = accept;
    meta_d.we     = bus.req_we;
    meta_d.funct3 = bus.req_funct3;
    meta_d.off    = effOff;
    meta_d.err    = reqErr;
  end

  // Response attribute shift register; reset drops every in-flight request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < RD_LAT; s++) begin
        meta_q[s] <= '0;
      end
    end else begin
      meta_q[0] <= meta_d;
      for (int s = 1; s < RD_LAT; s++) begin
        meta_q[s] <= meta_q[s-1];
      end
    end
  end

  // Extract and extend the addressed bytes at the pipeline output; zero for stores and errors
  always_comb begin
    meta_t               last;
    logic [DATA_WID-1:0] shifted;
    logic [DATA_WID-1:0] mask;
    logic [DATA_WID-1:0] value;
    int                  accBits;
    last    = meta_q[RD_LAT-1];
    shifted = data_q[RD_LAT-1] >> {last.off, 3'b000};
    accBits = 8 << last.funct3[1:0];
    mask    = '1;
    value   = shifted;
    if (accBits < DATA_WID) begin
      mask  = (ONE_W << accBits) - ONE_W;
      value = shifted & mask;
      if (!last.funct3[2] && shifted[accBits-1]) begin
        value = value | ~mask;
      end
    end
    bus.rsp_valid = last.valid;
    bus.rsp_err   = last.valid && last.err;
    bus.rsp_data  = (last.valid && !last.we && !last.err) ? value : '0;
  end

endmodule

// File: doc/rv_dmem_ctrl.md
Name: rv_dmem_ctrl

Overview:
- Parametrised RV data memory with a request/response port for the load/store unit; next generation of the core's data memory.
- Adds a clock, funct3-encoded access size (B/H/W/D, signed/unsigned), byte-lane write enables, a configurable-latency read pipeline and error reporting.
- Sits between the MEM stage and a single-port synchronous RAM array held inside the block.

Parameters:
- ADDR_WID, 32, byte address width.
- DATA_WID, 64, word width; legal values 32 or 64.
- DEPTH_LOG2, 10, log2 of the number of DATA_WID words.
- RD_LAT, 1, cycles from request accept to rsp_valid; legal 1..3.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  access request.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV funct3; [1:0] size 00 B/01 H/10 W/11 D; [2] unsigned (loads only).
- req_addr  in  ADDR_WID  byte address.
- req_wdata  in  DATA_WID  store data, right-aligned.
- rsp_valid  out  1  one-cycle pulse per accepted request, in request order.
- rsp_data  out  DATA_WID  load result after extension; 0 for stores and errors.
- rsp_err  out  1  access error, valid with rsp_valid.

Behaviour:
- OFF = log2(DATA_WID/8). Word index = req_addr[DEPTH_LOG2+OFF-1:OFF]. Upper address bits are ignored, so addresses alias. Byte offset = req_addr[OFF-1:0].
- req_ready = !rst. No backpressure: one request can be accepted every cycle, and responses cannot be stalled.
- Store:
  - Byte enables cover 1/2/4/8 bytes, left-shifted by the byte offset.
  - Store data is replicated across lanes; only the enabled bytes are written, at the accept edge.
  - funct3[2] is ignored for stores.
- Load:
  - The array is read at the accept edge.
  - Data passes through RD_LAT-1 further register stages.
  - The addressed bytes are extracted and sign-extended (funct3[2]=0) or zero-extended (funct3[2]=1) to DATA_WID.
- Write-first ordering: a load accepted the cycle after a store to the same word returns the new data. A store accepted after a load never changes that load's result.
- Response pipeline:
  - RD_LAT-deep shift of {valid, we, funct3, offset, err}.
  - rsp_valid is asserted exactly RD_LAT cycles after accept, for every request, loads and stores alike.
- Errors (rsp_err=1, rsp_data=0, no memory write):
  - size 11 when DATA_WID=32;
  - LWU (funct3=110) when DATA_WID=32;
  - misaligned access, when the misaligned check below is enabled.
- Reset:
  - rsp_valid, rsp_data and rsp_err go to 0 and all pipeline valid bits clear.
  - RAM contents are not reset.
  - Any in-flight request is dropped and produces no response.
  - A store accepted on the edge where rst rises is not guaranteed to be written.

Optional Feature:
- Macro: RV_DMEM_MISALIGN_CHK_EN.
- Defined: an access is misaligned when offset mod size-bytes ≠ 0. It gives rsp_err=1 and rsp_data=0, and a misaligned store does not write.
- Undefined: the offset bits below the access size are forced to 0, so the access is aligned down, and rsp_err covers only the width errors.

Test Plan:
- SD 0x1122334455667788 at 0x40, then LD 0x40 -> rsp_data 0x1122334455667788 RD_LAT cycles after the LD accept, rsp_err=0.
- SB 0xAB at 0x43, then LB 0x43 -> 0xFFFFFFFFFFFFFFAB; LBU 0x43 -> 0xAB; LD 0x40 -> 0x11223344AB667788.
- Back-to-back SW 0x8000_0001 at 0x10 then LW 0x10 in the next cycle -> 0xFFFFFFFF80000001, showing write-first ordering. Set RD_LAT=3 and issue 4 consecutive LDs -> 4 rsp_valid pulses in order.
- With RV_DMEM_MISALIGN_CHK_EN defined: LH 0x41 -> rsp_err=1, rsp_data=0; SW at 0x42 -> rsp_err=1 and memory unchanged. Without it: LH 0x41 returns the halfword at 0x40.
- DATA_WID=32: LD 0x0 -> rsp_err=1; LWU 0x0 -> rsp_err=1.
- Issue an LD, assert rst before rsp_valid, release rst -> no rsp_valid pulse; rsp_valid/rsp_data/rsp_err all 0 while in reset; earlier-written data is still readable afterwards.
